// File: rtl/lsu_store_buffer_pkg.sv
// Shared access-width codes, store-buffer entry layout and byte-count helper
// for the MEM-stage load/store front end.
package lsu_store_buffer_pkg;

  typedef enum logic [1:0] {
    W_BYTE = 2'b00,
    W_HALF = 2'b01,
    W_WORD = 2'b10,
    W_INV  = 2'b11
  } width_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  width;
    logic [31:0] wdata;
  } sb_entry_t;

  function automatic logic [2:0] width_nbytes(input logic [1:0] w);
    case (w)
      W_BYTE:  return 3'd1;
      W_HALF:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_store_buffer_match.sv
// Per-entry comparator: exact (addr,width) match and byte-range overlap
// between one buffered store and the current load.
module sb_entry_match
  import lsu_store_buffer_pkg::*;
(
  input  logic        valid_i,
  input  logic [31:0] e_addr_i,
  input  logic [1:0]  e_width_i,
  input  logic [31:0] ld_addr_i,
  input  logic [1:0]  ld_width_i,
  output logic        exact_match_o,
  output logic        overlap_o
);

  logic [32:0] e_lo, e_hi, l_lo, l_hi;

  // 33-bit ranges so an access ending at 0xFFFFFFFF never wraps to 0
  always_comb begin
    e_lo = {1'b0, e_addr_i};
    l_lo = {1'b0, ld_addr_i};
    e_hi = e_lo + 33'(width_nbytes(e_width_i)) - 33'd1;
    l_hi = l_lo + 33'(width_nbytes(ld_width_i)) - 33'd1;
    overlap_o     = valid_i && (e_lo <= l_hi) && (l_lo <= e_hi);
    exact_match_o = valid_i && (e_addr_i == ld_addr_i) && (e_width_i == ld_width_i);
  end

endmodule

// File: rtl/lsu_store_buffer.sv
// Store FIFO in front of a single-port data memory: loads own the port,
// stores drain when it is free, exact-match loads forward, partial overlaps stall.
module lsu_store_buffer
  import lsu_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  input  logic                         req_we,
  input  logic [31:0]                  req_addr,
  input  logic [1:0]                   req_width,
  input  logic                         req_usignext,
  input  logic [31:0]                  req_wdata,
  output logic                         req_ready,
  output logic [31:0]                  load_data,
  output logic                         mem_we,
  output logic [31:0]                  mem_address,
  output logic [1:0]                   mem_width,
  output logic                         mem_usignext,
  output logic [31:0]                  mem_w_data,
  input  logic [31:0]                  mem_r_data,
  output logic [$clog2(DEPTH+1)-1:0]   sb_count,
  output logic                         sb_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  sb_entry_t         entry_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic [DEPTH-1:0]  exact, ovl;
  logic              is_load, ld_inv, hazard, load_owns, drain, push, full;
  logic [31:0]       fwd_wdata, fwd_ext;
  logic [1:0]        fwd_width;
  logic [PW-1:0]     idx;

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    sb_entry_match u_match (
      .valid_i       (valid_q[g]),
      .e_addr_i      (entry_q[g].addr),
      .e_width_i     (entry_q[g].width),
      .ld_addr_i     (req_addr),
      .ld_width_i    (req_width),
      .exact_match_o (exact[g]),
      .overlap_o     (ovl[g])
    );
  end

  always_comb begin
    full      = (count_q == CW'(DEPTH));
    is_load   = req_valid && !req_we;
    ld_inv    = (req_width == W_INV);
    hazard    = is_load && !ld_inv && (|ovl) && !(|exact);
    load_owns = is_load && !hazard;
    drain     = !load_owns && (count_q != '0);
    push      = req_valid && req_we && !ld_inv && !full;
    req_ready = req_we ? (ld_inv || !full) : !hazard;
  end

  // Walk oldest to youngest from head so the last exact hit is the youngest store
  always_comb begin
    fwd_wdata = '0;
    fwd_width = W_BYTE;
    idx       = head_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (exact[idx]) begin
        fwd_wdata = entry_q[idx].wdata;
        fwd_width = entry_q[idx].width;
      end
    end
    case (fwd_width)
      W_BYTE:  fwd_ext = req_usignext ? {24'b0, fwd_wdata[7:0]}
                                      : {{24{fwd_wdata[7]}}, fwd_wdata[7:0]};
      W_HALF:  fwd_ext = req_usignext ? {16'b0, fwd_wdata[15:0]}
                                      : {{16{fwd_wdata[15]}}, fwd_wdata[15:0]};
      default: fwd_ext = fwd_wdata;
    endcase
    load_data = '0;
    if (load_owns && !ld_inv) load_data = (|exact) ? fwd_ext : mem_r_data;
  end

  always_comb begin
    mem_we       = 1'b0;
    mem_address  = '0;
    mem_width    = '0;
    mem_usignext = 1'b0;
    mem_w_data   = '0;
    if (load_owns) begin
      mem_address  = req_addr;
      mem_width    = req_width;
      mem_usignext = req_usignext;
    end else if (drain) begin
      mem_we      = 1'b1;
      mem_address = entry_q[head_q].addr;
      mem_width   = entry_q[head_q].width;
      mem_w_data  = entry_q[head_q].wdata;
    end
  end

  always_comb begin
    head_d  = drain ? head_q + PW'(1) : head_q;
    tail_d  = push  ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({push, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        entry_q[tail_q] <= '{addr: req_addr, width: req_width, wdata: req_wdata};
        valid_q[tail_q] <= 1'b1;
      end
      if (drain) valid_q[head_q] <= 1'b0;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign sb_count = count_q;
  assign sb_empty = (count_q == '0);

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Randomized bench: big-endian byte memory plus a program-order store queue
// model giving the architectural value every accepted load must return.
module tb_lsu_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_we, req_usignext;
  logic [31:0]   req_addr, req_wdata;
  logic [1:0]    req_width;
  logic          req_ready;
  logic [31:0]   load_data;
  logic          mem_we, mem_usignext;
  logic [31:0]   mem_address, mem_w_data, mem_r_data;
  logic [1:0]    mem_width;
  logic [CW-1:0] sb_count;
  logic          sb_empty;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_width(req_width), .req_usignext(req_usignext), .req_wdata(req_wdata),
    .req_ready(req_ready), .load_data(load_data),
    .mem_we(mem_we), .mem_address(mem_address), .mem_width(mem_width),
    .mem_usignext(mem_usignext), .mem_w_data(mem_w_data), .mem_r_data(mem_r_data),
    .sb_count(sb_count), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  // ---------------- environment memory ----------------
  logic [7:0] mem [256];
  logic       init_mem;
  logic [7:0] ra;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 29 + 8'h91);
  endfunction

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (mem_we) begin
      case (mem_width)
        2'b00: mem[mem_address[7:0]] <= mem_w_data[7:0];
        2'b01: begin
          mem[mem_address[7:0]]        <= mem_w_data[15:8];
          mem[8'(mem_address[7:0] + 1)] <= mem_w_data[7:0];
        end
        2'b10: begin
          mem[mem_address[7:0]]        <= mem_w_data[31:24];
          mem[8'(mem_address[7:0] + 1)] <= mem_w_data[23:16];
          mem[8'(mem_address[7:0] + 2)] <= mem_w_data[15:8];
          mem[8'(mem_address[7:0] + 3)] <= mem_w_data[7:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ra = mem_address[7:0];
    case (mem_width)
      2'b00: mem_r_data = mem_usignext ? {24'b0, mem[ra]} : {{24{mem[ra][7]}}, mem[ra]};
      2'b01: mem_r_data = mem_usignext ? {16'b0, mem[ra], mem[8'(ra+1)]}
                                       : {{16{mem[ra][7]}}, mem[ra], mem[8'(ra+1)]};
      2'b10: mem_r_data = {mem[ra], mem[8'(ra+1)], mem[8'(ra+2)], mem[8'(ra+3)]};
      default: mem_r_data = '0;
    endcase
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  w;
    logic [31:0] d;
  } st_t;

  st_t        q[$];
  logic [7:0] ref_mem [256];

  function automatic int nb(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [7:0] arch_byte(input logic [31:0] a);
    logic [7:0] v;
    int off;
    v = ref_mem[a[7:0]];
    foreach (q[k]) begin
      off = int'(a) - int'(q[k].addr);
      if (off >= 0 && off < nb(q[k].w)) v = q[k].d[(nb(q[k].w) - 1 - off) * 8 +: 8];
    end
    return v;
  endfunction

  function automatic logic [31:0] arch_read(input logic [31:0] a, input logic [1:0] w,
                                            input logic us);
    logic [7:0]  b;
    logic [15:0] h;
    case (w)
      2'b00: begin b = arch_byte(a); return us ? {24'b0, b} : {{24{b[7]}}, b}; end
      2'b01: begin
        h = {arch_byte(a), arch_byte(a + 1)};
        return us ? {16'b0, h} : {{16{h[15]}}, h};
      end
      2'b10: return {arch_byte(a), arch_byte(a + 1), arch_byte(a + 2), arch_byte(a + 3)};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_hazard(input logic [31:0] a, input logic [1:0] w);
    bit ov, ex;
    longint lo, hi, elo, ehi;
    ov = 0; ex = 0;
    lo = longint'(a); hi = lo + nb(w) - 1;
    foreach (q[k]) begin
      elo = longint'(q[k].addr); ehi = elo + nb(q[k].w) - 1;
      if (elo <= hi && lo <= ehi) ov = 1;
      if (q[k].addr == a && q[k].w == w) ex = 1;
    end
    return ov && !ex;
  endfunction

  function automatic void ref_write(input st_t s);
    for (int i = 0; i < nb(s.w); i++)
      ref_mem[8'(s.addr[7:0] + 8'(i))] = s.d[(nb(s.w) - 1 - i) * 8 +: 8];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request cycle: drive at negedge, check combinational outputs, advance model.
  task automatic step(input logic v, input logic we, input logic [31:0] a,
                      input logic [1:0] w, input logic us, input logic [31:0] d);
    bit is_load, hz, owns, drn, psh;
    st_t s;
    @(negedge clk);
    req_valid = v; req_we = we; req_addr = a; req_width = w;
    req_usignext = us; req_wdata = d;
    #1;
    is_load = v && !we;
    hz      = is_load && (w != 2'b11) && model_hazard(a, w);
    owns    = is_load && !hz;
    drn     = !owns && (q.size() > 0);
    psh     = v && we && (w != 2'b11) && (q.size() < DEPTH);
    check_eq("sb_count", 32'(sb_count), 32'(q.size()));
    check_eq("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
    if (v) check_eq("req_ready", 32'(req_ready),
                    we ? 32'((w == 2'b11) || (q.size() < DEPTH)) : 32'(!hz));
    check_eq("mem_we", 32'(mem_we), 32'(drn));
    if (drn) begin
      check_eq("drain_addr", mem_address, q[0].addr);
      check_eq("drain_width", 32'(mem_width), 32'(q[0].w));
      check_eq("drain_data", mem_w_data, q[0].d);
    end
    if (owns) begin
      check_eq("load_addr", mem_address, a);
      check_eq("load_data", load_data, arch_read(a, w, us));
    end
    if (drn) begin
      ref_write(q[0]);
      void'(q.pop_front());
    end
    if (psh) begin
      s.addr = a; s.w = w; s.d = d;
      q.push_back(s);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
  endtask

  initial begin
    int bad;
    logic [31:0] a;
    logic [1:0]  w;
    rst = 1'b1; init_mem = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_width = '0;
    req_usignext = 1'b0; req_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; init_mem = 1'b0;
    #1;
    check_eq("rst_count", 32'(sb_count), 32'h0);
    check_eq("rst_empty", 32'(sb_empty), 32'h1);
    check_eq("rst_mem_we", 32'(mem_we), 32'h0);

    // store then drain next cycle
    step(1, 1, 32'h10, 2'b10, 0, 32'hDEADBEEF);
    step(0, 0, 32'h0, 2'b00, 0, 32'h0);
    check_eq("t1_we", 32'(mem_we), 32'h1);
    check_eq("t1_addr", mem_address, 32'h10);
    check_eq("t1_width", 32'(mem_width), 32'h2);
    idle(1);

    // word forward
    step(1, 1, 32'h20, 2'b10, 0, 32'h11223344);
    step(1, 0, 32'h20, 2'b10, 0, 32'h0);
    check_eq("t2_data", load_data, 32'h11223344);
    check_eq("t2_ready", 32'(req_ready), 32'h1);
    check_eq("t2_we", 32'(mem_we), 32'h0);

    // byte forward, signed and unsigned
    step(1, 1, 32'h30, 2'b00, 0, 32'hAAAAAA80);
    step(1, 0, 32'h30, 2'b00, 0, 32'h0);
    check_eq("t3_signed", load_data, 32'hFFFFFF80);
    step(1, 0, 32'h30, 2'b00, 1, 32'h0);
    check_eq("t3_unsigned", load_data, 32'h00000080);
    idle(2);

    // partial overlap stalls, drains, then reads memory
    step(1, 1, 32'h40, 2'b10, 0, 32'hCAFEF00D);
    step(1, 0, 32'h42, 2'b01, 1, 32'h0);
    check_eq("t4_stall", 32'(req_ready), 32'h0);
    check_eq("t4_drain", 32'(mem_we), 32'h1);
    step(1, 0, 32'h42, 2'b01, 1, 32'h0);
    check_eq("t4_ready", 32'(req_ready), 32'h1);
    check_eq("t4_data", load_data, 32'h0000F00D);

    // loads block drains; store in a drain cycle keeps occupancy
    step(1, 1, 32'h50, 2'b10, 0, 32'h0BADF00D);
    step(1, 0, 32'h80, 2'b10, 0, 32'h0);
    step(1, 0, 32'h84, 2'b10, 0, 32'h0);
    step(1, 1, 32'h54, 2'b10, 0, 32'h55667788);
    step(1, 0, 32'h88, 2'b10, 0, 32'h0);
    check_eq("t5_count", 32'(sb_count), 32'h1);

    // invalid width
    step(1, 1, 32'h58, 2'b11, 0, 32'hFFFFFFFF);
    step(1, 0, 32'h58, 2'b11, 0, 32'h0);
    check_eq("inv_load", load_data, 32'h0);
    check_eq("inv_ready", 32'(req_ready), 32'h1);

    // reset with a buffered store held back by a load
    step(1, 1, 32'h60, 2'b10, 0, 32'h12345678);
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'hF0; req_width = 2'b10;
    #1 check_eq("t6_rst_we", 32'(mem_we), 32'h0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    q.delete();
    #1;
    check_eq("t6_count", 32'(sb_count), 32'h0);
    check_eq("t6_empty", 32'(sb_empty), 32'h1);
    check_eq("t6_mem_we", 32'(mem_we), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      w = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 15) * 4);
      if (w == 2'b00) a = a + 32'($urandom_range(0, 3));
      else if (w == 2'b01) a = a + 32'($urandom_range(0, 1) * 2);
      step(1'($urandom_range(0, 99) < 85), 1'($urandom_range(0, 1)), a, w,
           1'($urandom_range(0, 1)), $urandom);
    end
    idle(DEPTH + 2);

    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check_eq("mem_image", 32'(bad), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
